// File: rtl/enable_counter_if.sv
// Count bus between a requester and enable_counter: the enable request plus
// the registered count value and its update flag.
interface enable_counter_if #(
    parameter int WIDTH = 5
) ();
    logic             enable;
    logic [WIDTH-1:0] contador;
    logic             valid;

    modport master (
        output enable,
        input  contador,
        input  valid
    );

    modport slave (
        input  enable,
        output contador,
        output valid
    );
endinterface

// File: rtl/enable_counter.sv
// Registered up-counter with an update flag. It wraps modulo 2^WIDTH by default.
// Defining ENABLE_COUNTER_SATURATE_EN makes it stop at 2^WIDTH-1 instead.
module enable_counter #(
    parameter int WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    enable_counter_if.slave     bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             valid_reg;
    logic             valid_next;

    always_comb begin
        count_next = count_reg;
        valid_next = 1'b0;
        if (bus.enable) begin
`ifdef ENABLE_COUNTER_SATURATE_EN
            // valid reports an actual change, so it stays low once the count is pinned at max
            if (count_reg != {WIDTH{1'b1}}) begin
                count_next = count_reg + ONE;
                valid_next = 1'b1;
            end
`else
            count_next = count_reg + ONE;
            valid_next = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.contador = count_reg;
    assign bus.valid    = valid_reg;
endmodule

// File: tb/tb_enable_counter.sv
// Directed self-checking bench for enable_counter. It uses a WIDTH=5 instance and a WIDTH=3 instance.
// The bench follows the wrap or saturate build through ENABLE_COUNTER_SATURATE_EN.
module tb_enable_counter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    enable_counter_if #(.WIDTH(5)) bus5 ();
    enable_counter_if #(.WIDTH(3)) bus3 ();

    enable_counter #(.WIDTH(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    enable_counter #(.WIDTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic e5, input logic e3);
        @(negedge clk);
        bus5.enable = e5;
        bus3.enable = e3;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus5.enable = 1'b0;
        bus3.enable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus5.enable = 1'b1;
        bus3.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus5.contador !== 5'd0) begin
                errors++;
                $display("FAIL reset_contador edge %0d: got %0d expected 0", i, bus5.contador);
            end
            checks++;
            if (bus5.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid edge %0d: got %b expected 0", i, bus5.valid);
            end
            checks++;
            if (bus3.contador !== 3'd0) begin
                errors++;
                $display("FAIL reset_contador_w3 edge %0d: got %0d expected 0", i, bus3.contador);
            end
        end
        @(negedge clk);
        bus5.enable = 1'b0;
        bus3.enable = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus5.contador !== 5'd0 || bus5.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got contador=%0d valid=%b expected 0/0",
                     bus5.contador, bus5.valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_continuous();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (bus5.contador !== 5'(i) || bus5.valid !== 1'b1) begin
                errors++;
                $display("FAIL continuous step %0d: got contador=%0d valid=%b expected %0d/1",
                         i, bus5.contador, bus5.valid, i);
            end
        end
        $display("test_continuous done");
    endtask

    task automatic test_pattern();
        logic       pat [4];
        logic [4:0] exp_c [4];
        logic       exp_v [4];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_c = '{5'd5, 5'd5, 5'd5, 5'd6};
        exp_v = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        checks++;
        if (bus5.contador !== 5'd4) begin
            errors++;
            $display("FAIL pattern_preload: got %0d expected 4", bus5.contador);
        end
        for (int i = 0; i < 4; i++) begin
            drive(pat[i], 1'b0);
            checks++;
            if (bus5.contador !== exp_c[i] || bus5.valid !== exp_v[i]) begin
                errors++;
                $display("FAIL pattern step %0d: got contador=%0d valid=%b expected %0d/%b",
                         i, bus5.contador, bus5.valid, exp_c[i], exp_v[i]);
            end
        end
        $display("test_pattern done");
    endtask

    task automatic test_wrap();
        logic [4:0] exp_c;
        logic       exp_v;
        int         n;
        do_reset();
`ifdef ENABLE_COUNTER_SATURATE_EN
        n = 35;
`else
        n = 33;
`endif
        for (int i = 1; i <= n; i++) begin
`ifdef ENABLE_COUNTER_SATURATE_EN
            exp_c = (i >= 31) ? 5'd31 : 5'(i);
            exp_v = (i <= 31);
`else
            exp_c = 5'(i % 32);
            exp_v = 1'b1;
`endif
            drive(1'b1, 1'b0);
            checks++;
            if (bus5.contador !== exp_c || bus5.valid !== exp_v) begin
                errors++;
                $display("FAIL wrap step %0d: got contador=%0d valid=%b expected %0d/%b",
                         i, bus5.contador, bus5.valid, exp_c, exp_v);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 13; i++) drive(1'b1, 1'b0);
        checks++;
        if (bus5.contador !== 5'd13 || bus5.valid !== 1'b1) begin
            errors++;
            $display("FAIL async_preload: got contador=%0d valid=%b expected 13/1",
                     bus5.contador, bus5.valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus5.contador !== 5'd0 || bus5.valid !== 1'b0) begin
            errors++;
            $display("FAIL async_midcycle: got contador=%0d valid=%b expected 0/0",
                     bus5.contador, bus5.valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus5.contador !== 5'd0 || bus5.valid !== 1'b0) begin
                errors++;
                $display("FAIL async_hold edge %0d: got contador=%0d valid=%b expected 0/0",
                         i, bus5.contador, bus5.valid);
            end
        end
        @(negedge clk);
        bus5.enable = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus5.contador !== 5'd0 || bus5.valid !== 1'b0) begin
            errors++;
            $display("FAIL async_release_idle: got contador=%0d valid=%b expected 0/0",
                     bus5.contador, bus5.valid);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (bus5.contador !== 5'd1 || bus5.valid !== 1'b1) begin
            errors++;
            $display("FAIL async_first_count: got contador=%0d valid=%b expected 1/1",
                     bus5.contador, bus5.valid);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_width3();
        logic [2:0] exp_c;
        logic       exp_v;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
`ifdef ENABLE_COUNTER_SATURATE_EN
            exp_c = (i >= 7) ? 3'd7 : 3'(i);
            exp_v = (i <= 7);
`else
            exp_c = 3'(i % 8);
            exp_v = 1'b1;
`endif
            drive(1'b0, 1'b1);
            checks++;
            if (bus3.contador !== exp_c || bus3.valid !== exp_v) begin
                errors++;
                $display("FAIL width3 step %0d: got contador=%0d valid=%b expected %0d/%b",
                         i, bus3.contador, bus3.valid, exp_c, exp_v);
            end
        end
        $display("test_width3 done");
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        bus5.enable = 1'b0;
        bus3.enable = 1'b0;
        errors = 0;
        checks = 0;
        test_reset();
        test_continuous();
        test_pattern();
        test_wrap();
        test_async_reset();
        test_width3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/enable_counter.md
ENABLE_COUNTER -- requirements
Module: enable_counter

Interface
REQ-001 Parameter: WIDTH, default 5, bit width of the count output; legal range 1..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; rst=0 resets the block.
REQ-004 Port: enable  input  1  count request, sampled on each rising clk edge.
REQ-005 Port: contador  output  WIDTH  current count value, registered.
REQ-006 Port: valid  output  1  registered flag; high for the cycle after a count update.

Function
REQ-007 Both outputs SHALL come directly from flops, with no combinational path from enable to either output.
REQ-008 On a rising clk edge with rst=1 and enable=1, contador SHALL become contador+1 and valid SHALL become 1.
REQ-009 On a rising clk edge with rst=1 and enable=0, contador SHALL hold its value and valid SHALL become 0.
REQ-010 Latency: the increment SHALL appear on contador in the cycle after enable is sampled high; valid SHALL rise in that same cycle.
REQ-011 Continuous enable SHALL give one increment per clock with valid held high; a single-cycle enable pulse SHALL give exactly one increment and a one-cycle valid pulse.
REQ-012 Wrap-around (macro absent): when contador = 2^WIDTH-1 and enable=1, contador SHALL become 0 and valid SHALL become 1.
REQ-013 Arithmetic SHALL be unsigned and modulo 2^WIDTH; no carry or overflow output exists.
REQ-014 enable SHALL have no effect while rst=0.

Reset
REQ-015 rst=0 SHALL force contador=0 and valid=0 immediately, independent of clk.
REQ-016 Reset asserted mid-count SHALL discard the current count, and the outputs SHALL stay at 0 while rst=0.
REQ-017 After rst deasserts, the first increment SHALL require a rising edge with enable=1; the next value after reset SHALL be 1.

Configuration
REQ-018 Macro ENABLE_COUNTER_SATURATE_EN SHALL select saturation mode when defined.
REQ-019 With ENABLE_COUNTER_SATURATE_EN defined, contador SHALL stop at 2^WIDTH-1 under continued enable instead of wrapping.
REQ-020 In saturation mode, valid SHALL be 1 only on edges where contador actually changed, so valid=0 once contador is saturated, even with enable=1.
REQ-021 Without ENABLE_COUNTER_SATURATE_EN, the behaviour SHALL be the wrap-around of REQ-012, with no saturation logic present.

Verification
REQ-022 Scenario: rst=0 asserted asynchronously mid-cycle with contador=13 -> contador=0 and valid=0 before the next clk edge.
REQ-023 Scenario: rst=1, enable=1 for 10 cycles from 0 (WIDTH=5) -> contador steps 1..10 and valid=1 for each of those 10 cycles.
REQ-024 Scenario: enable pattern 1,0,0,1 from contador=4 -> contador 5,5,5,6 and valid 1,0,0,1.
REQ-025 Scenario (default build): enable=1 for 33 cycles from 0 -> contador reaches 31, then 0, then 1; valid stays 1 throughout.
REQ-026 Scenario (ENABLE_COUNTER_SATURATE_EN defined): enable=1 for 35 cycles from 0 -> contador holds at 31 and valid=0 from the 32nd cycle on.
REQ-027 Scenario: WIDTH=3 with enable held high -> contador sequence 1..7, 0, 1.
